// File: rtl/tt_input_debouncer_if.sv
// Change-event channel of the input debouncer: one-entry, latest-wins,
// valid/ready handshake with a sticky overflow flag.
interface tt_input_debouncer_if #(
  parameter int WIDTH = 8
);
  logic             evt_valid;
  logic [WIDTH-1:0] evt_data;
  logic             evt_ready;
  logic             evt_overflow;

  modport master (
    output evt_valid,
    output evt_data,
    output evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/tt_input_debouncer.sv
// Pad-input conditioner: per-bit synchroniser, per-bit debounce counter,
// clean levels with rise/fall strobes and a change-event channel.
module tt_input_debouncer #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [WIDTH-1:0]      raw_in,
  output logic [WIDTH-1:0]      clean_out,
  output logic [WIDTH-1:0]      rise_pulse,
  output logic [WIDTH-1:0]      fall_pulse,
  tt_input_debouncer_if.master  evt
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_data_q, evt_data_d;
  logic             evt_ovf_q, evt_ovf_d;
  logic             chg;

  // Synchroniser keeps running while ena is low so it is settled on re-enable.
  always_comb begin
    sync_d[0] = raw_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!ena) begin
        cnt_d[i] = '0;
      end else if (sync_s[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        clean_d[i] = sync_s[i];
        cnt_d[i]   = '0;
        rise_d[i]  = sync_s[i];
        fall_d[i]  = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A change arriving in the same cycle as an accept re-arms the slot with the
  // new vector; overflow only latches when the old event was still unaccepted.
  assign chg = |(clean_d ^ clean_q);

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    evt_ovf_d   = evt_ovf_q;
    if (evt_valid_q && evt.evt_ready) begin
      evt_valid_d = 1'b0;
      evt_ovf_d   = 1'b0;
    end
    if (chg) begin
      evt_valid_d = 1'b1;
      evt_data_d  = clean_d;
      if (evt_valid_q && !evt.evt_ready) begin
        evt_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign clean_out        = clean_q;
  assign rise_pulse       = rise_q;
  assign fall_pulse       = fall_q;
  assign evt.evt_valid    = evt_valid_q;
  assign evt.evt_data     = evt_data_q;
  assign evt.evt_overflow = evt_ovf_q;

endmodule

// File: tb/tb_tt_input_debouncer.sv
// Directed bench for tt_input_debouncer at SYNC_STAGES=2, DEBOUNCE_CYCLES=4:
// a vector table for the main sequence plus hand-written corner sequences.
module tb_tt_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] raw_in;
  logic [7:0] clean_out;
  logic [7:0] rise_pulse;
  logic [7:0] fall_pulse;

  int passed = 0;
  int total  = 0;

  tt_input_debouncer_if #(.WIDTH(8)) evt_if ();

  tt_input_debouncer #(
    .WIDTH           (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .evt        (evt_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] raw;
    logic       en;
    logic       rdy;
    int         ticks;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       valid;
    logic [7:0] data;
    logic       ovf;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_all(input string nm, input logic [7:0] e_clean, input logic [7:0] e_rise,
                           input logic [7:0] e_fall, input logic e_valid, input logic [7:0] e_data,
                           input logic e_ovf);
    chk({nm, ".clean"}, clean_out, e_clean);
    chk({nm, ".rise"},  rise_pulse, e_rise);
    chk({nm, ".fall"},  fall_pulse, e_fall);
    chk({nm, ".valid"}, {7'd0, evt_if.evt_valid}, {7'd0, e_valid});
    chk({nm, ".data"},  evt_if.evt_data, e_data);
    chk({nm, ".ovf"},   {7'd0, evt_if.evt_overflow}, {7'd0, e_ovf});
  endtask

  initial begin
    //          name          raw    en  rdy  n  clean  rise   fall   v  data   ovf
    tbl[0]  = '{"glitch_hi",  8'h01, 1, 0, 3, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0};
    tbl[1]  = '{"glitch_lo",  8'h00, 1, 0, 6, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0};
    tbl[2]  = '{"b0_pre",     8'h01, 1, 0, 5, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0};
    tbl[3]  = '{"b0_acc",     8'h01, 1, 0, 1, 8'h01, 8'h01, 8'h00, 1, 8'h01, 0};
    tbl[4]  = '{"b0_strb",    8'h01, 1, 0, 1, 8'h01, 8'h00, 8'h00, 1, 8'h01, 0};
    tbl[5]  = '{"hs_acc",     8'h01, 1, 1, 1, 8'h01, 8'h00, 8'h00, 0, 8'h01, 0};
    tbl[6]  = '{"b1_rise",    8'h03, 1, 0, 6, 8'h03, 8'h02, 8'h00, 1, 8'h03, 0};
    tbl[7]  = '{"ovf_set",    8'h07, 1, 0, 6, 8'h07, 8'h04, 8'h00, 1, 8'h07, 1};
    tbl[8]  = '{"ovf_acc",    8'h07, 1, 1, 1, 8'h07, 8'h00, 8'h00, 0, 8'h07, 0};
    tbl[9]  = '{"idle",       8'h07, 1, 0, 1, 8'h07, 8'h00, 8'h00, 0, 8'h07, 0};
    tbl[10] = '{"b0_fall",    8'h06, 1, 0, 6, 8'h06, 8'h00, 8'h01, 1, 8'h06, 0};
    tbl[11] = '{"b1_pre",     8'h04, 1, 0, 5, 8'h06, 8'h00, 8'h00, 1, 8'h06, 0};
    tbl[12] = '{"acc_chg",    8'h04, 1, 1, 1, 8'h04, 8'h00, 8'h02, 1, 8'h04, 0};
    tbl[13] = '{"hold",       8'h04, 1, 0, 1, 8'h04, 8'h00, 8'h00, 1, 8'h04, 0};
    tbl[14] = '{"acc2",       8'h04, 1, 1, 1, 8'h04, 8'h00, 8'h00, 0, 8'h04, 0};
    tbl[15] = '{"multi",      8'hFB, 1, 0, 6, 8'hFB, 8'hFB, 8'h04, 1, 8'hFB, 0};
    tbl[16] = '{"multi_one",  8'hFB, 1, 0, 1, 8'hFB, 8'h00, 8'h00, 1, 8'hFB, 0};

    // Reset with inputs high, then release and hold.
    rst_n = 1'b0;
    ena = 1'b1;
    raw_in = 8'hFF;
    evt_if.evt_ready = 1'b0;
    repeat (3) tick();
    check_all("rst", 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check_all("rel_e5", 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
    tick();
    check_all("rel_e6", 8'hFF, 8'hFF, 8'h00, 1, 8'hFF, 0);
    tick();
    check_all("rel_e7", 8'hFF, 8'h00, 8'h00, 1, 8'hFF, 0);

    // Async reset mid-operation clears everything without a clock edge.
    #2;
    rst_n = 1'b0;
    raw_in = 8'h00;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    for (int r = 0; r < 17; r++) begin
      raw_in = tbl[r].raw;
      ena = tbl[r].en;
      evt_if.evt_ready = tbl[r].rdy;
      repeat (tbl[r].ticks) tick();
      check_all(tbl[r].name, tbl[r].clean, tbl[r].rise, tbl[r].fall,
                tbl[r].valid, tbl[r].data, tbl[r].ovf);
    end

    // ena low freezes debouncing while the synchroniser settles.
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    ena = 1'b0;
    raw_in = 8'h0F;
    repeat (10) tick();
    check_all("ena_frz", 8'hFB, 8'h00, 8'h00, 0, 8'hFB, 0);
    ena = 1'b1;
    repeat (3) tick();
    check_all("ena_e3", 8'hFB, 8'h00, 8'h00, 0, 8'hFB, 0);
    tick();
    check_all("ena_e4", 8'h0F, 8'h04, 8'hF0, 1, 8'h0F, 0);

    // ena drop mid-count discards the partial count.
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    raw_in = 8'h00;
    repeat (4) tick();
    ena = 1'b0;
    tick();
    check_all("mid_off", 8'h0F, 8'h00, 8'h00, 0, 8'h0F, 0);
    ena = 1'b1;
    repeat (3) tick();
    check_all("mid_e3", 8'h0F, 8'h00, 8'h00, 0, 8'h0F, 0);
    tick();
    check_all("mid_e4", 8'h00, 8'h00, 8'h0F, 1, 8'h00, 0);

    // Reset while an event is pending drops it.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst_pend", 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
